// File: rtl/link_test_sequencer.sv
// link_test_sequencer
//  Runs one link test over the FSK/Hamming datapath: pulses the datapath
//  reset, then for each of NUM_WORDS nibbles fetches it from the source,
//  hands it to the encoder and waits for the decoded nibble. Matches,
//  mismatches and per-word timeouts are tallied in saturating counters.
//  A timeout re-enters the datapath reset to re-synchronise the chain.
module link_test_sequencer #(
  parameter int NUM_WORDS  = 16,
  parameter int TIMEOUT    = 4096,
  parameter int RST_CYCLES = 15,
  parameter int CNT_W      = 16
) (
  input  logic             sys_clock,
  input  logic             reset_original,
  input  logic             start,
  input  logic [3:0]       src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [3:0]       enc_data,
  output logic             enc_valid,
  input  logic             enc_ready,
  input  logic [3:0]       dec_data,
  input  logic             dec_valid,
  output logic             dp_reset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] timeout_count
);

  // Wait timer only ever needs to reach TIMEOUT-1; reset counter RST_CYCLES-1.
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT - 1);
  localparam logic [RST_W-1:0] RST_LAST    = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORDS_TOTAL = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DP_RST = 3'd1,
    S_FETCH  = 3'd2,
    S_SEND   = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       word_q, word_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic src_ready_q, src_ready_d;
  logic enc_valid_q, enc_valid_d;
  logic dp_reset_q, dp_reset_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Word count after the current word finishes; decides FETCH vs DONE.
  logic [CNT_W-1:0] word_cnt_inc;
  logic             timer_expired;
  logic             rst_last;

  assign word_cnt_inc  = sat_inc(word_cnt_q);
  assign timer_expired = (timer_q == TMR_LAST);
  assign rst_last      = (rst_cnt_q == RST_LAST);

  // State register with synchronous reset.
  always_ff @(posedge sys_clock) begin
    if (reset_original) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dec_valid takes priority over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DP_RST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DP_RST: begin
        if (rst_last) begin
          if (word_cnt_q == WORDS_TOTAL) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_DP_RST;
        end
      end
      S_FETCH: begin
        if (src_valid) begin
          state_d = S_SEND;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_SEND: begin
        if (enc_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT: begin
        if (dec_valid) begin
          if (word_cnt_inc == WORDS_TOTAL) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else if (timer_expired) begin
          state_d = S_DP_RST;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the handshake outputs leave a flop.
  always_comb begin
    src_ready_d = (state_d == S_FETCH);
    enc_valid_d = (state_d == S_SEND);
    dp_reset_d  = (state_d == S_DP_RST);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // Output registers.
  always_ff @(posedge sys_clock) begin
    if (reset_original) begin
      src_ready_q <= 1'b0;
      enc_valid_q <= 1'b0;
      dp_reset_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      src_ready_q <= src_ready_d;
      enc_valid_q <= enc_valid_d;
      dp_reset_q  <= dp_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Datapath next values: reset-pulse length, wait timer, captured word, tallies.
  always_comb begin
    rst_cnt_d  = '0;
    timer_d    = '0;
    word_d     = word_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_cnt_d = '0;
          err_cnt_d  = '0;
          tmo_cnt_d  = '0;
        end else begin
          word_cnt_d = word_cnt_q;
        end
      end
      S_DP_RST: begin
        if (rst_last) begin
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_FETCH: begin
        if (src_valid) begin
          word_d = src_data;
        end else begin
          word_d = word_q;
        end
      end
      S_SEND: begin
        // Timer starts from zero on the first WAIT cycle after the handshake.
        timer_d = '0;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (dec_valid) begin
          word_cnt_d = word_cnt_inc;
          if (dec_data != word_q) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end else if (timer_expired) begin
          word_cnt_d = word_cnt_inc;
          err_cnt_d  = sat_inc(err_cnt_q);
          tmo_cnt_d  = sat_inc(tmo_cnt_q);
        end else begin
          word_cnt_d = word_cnt_q;
        end
      end
      S_DONE: begin
        word_cnt_d = word_cnt_q;
      end
      default: begin
        word_cnt_d = word_cnt_q;
      end
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge sys_clock) begin
    if (reset_original) begin
      rst_cnt_q  <= '0;
      timer_q    <= '0;
      word_q     <= 4'h0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      rst_cnt_q  <= rst_cnt_d;
      timer_q    <= timer_d;
      word_q     <= word_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign src_ready     = src_ready_q;
  assign enc_valid     = enc_valid_q;
  assign enc_data      = word_q;
  assign dp_reset      = dp_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign word_count    = word_cnt_q;
  assign err_count     = err_cnt_q;
  assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_link_test_sequencer.sv
// tb_link_test_sequencer
//  Drives source, encoder and decoder sides of the sequencer and tracks a
//  transaction-level model of the test run (which protocol phase is open,
//  how long the reset pulse still lasts, how each word resolves).
module tb_link_test_sequencer;

  localparam int NW = 4;
  localparam int TO = 64;
  localparam int RC = 15;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_original = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    src_data = 4'h0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [3:0]    enc_data;
  logic          enc_valid;
  logic          enc_ready = 1'b0;
  logic [3:0]    dec_data = 4'h0;
  logic          dec_valid = 1'b0;
  logic          dp_reset;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_count;
  logic [CW-1:0] err_count;
  logic [CW-1:0] timeout_count;

  link_test_sequencer #(
    .NUM_WORDS (NW),
    .TIMEOUT   (TO),
    .RST_CYCLES(RC),
    .CNT_W     (CW)
  ) dut (
    .sys_clock     (clk),
    .reset_original(reset_original),
    .start         (start),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .enc_data      (enc_data),
    .enc_valid     (enc_valid),
    .enc_ready     (enc_ready),
    .dec_data      (dec_data),
    .dec_valid     (dec_valid),
    .dp_reset      (dp_reset),
    .busy          (busy),
    .done          (done),
    .word_count    (word_count),
    .err_count     (err_count),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model of the run
  logic          m_active = 1'b0;
  logic          m_fetch  = 1'b0;
  logic          m_send   = 1'b0;
  logic          m_wait   = 1'b0;
  logic          m_done   = 1'b0;
  int            m_rst_left = 0;
  int            m_age = 0;
  logic [3:0]    m_cur = 4'h0;
  logic [CW-1:0] m_wc = '0;
  logic [CW-1:0] m_ec = '0;
  logic [CW-1:0] m_tc = '0;

  // Environment
  logic [3:0] srcq[$];
  int         pl_delay[NW];
  logic       pl_corrupt[NW];
  logic       dec_pend = 1'b0;
  int         dec_at = 0;
  logic [3:0] dec_word = 4'h0;
  logic       rnd_src = 1'b0;
  logic       rnd_ready = 1'b0;
  logic       stray_dec = 1'b0;
  logic       stray_start = 1'b0;
  int         hold_left = 0;

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_plan(input int d);
    for (int i = 0; i < NW; i++) begin
      pl_delay[i]   = d;
      pl_corrupt[i] = 1'b0;
    end
  endtask

  // One clock: record what the DUT samples, advance the model, compare, drive.
  task automatic step();
    logic       ev_rst, ev_start, ev_acc, ev_hs, ev_dv, was_done;
    logic [3:0] ev_sd, ev_dd;
    int         idx;
    ev_rst   = reset_original;
    ev_start = start;
    ev_acc   = m_fetch & src_valid;
    ev_sd    = src_data;
    ev_hs    = m_send & enc_ready;
    ev_dv    = dec_valid;
    ev_dd    = dec_data;
    @(posedge clk);
    #1;
    cyc++;
    if (ev_rst) begin
      m_active = 1'b0; m_fetch = 1'b0; m_send = 1'b0; m_wait = 1'b0; m_done = 1'b0;
      m_rst_left = 0; m_age = 0; m_cur = 4'h0;
      m_wc = '0; m_ec = '0; m_tc = '0;
      dec_pend = 1'b0;
      srcq.delete();
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (m_rst_left > 0) begin
        m_rst_left--;
        if (m_rst_left == 0) begin
          if (m_wc == 16'(NW)) m_done = 1'b1;
          else                 m_fetch = 1'b1;
        end
      end
      if (ev_start && !m_active) begin
        m_active = 1'b1;
        m_wc = '0; m_ec = '0; m_tc = '0;
        m_rst_left = RC;
      end
      if (was_done) m_active = 1'b0;
      if (ev_acc) begin
        m_fetch = 1'b0;
        m_send  = 1'b1;
        m_cur   = ev_sd;
        if (srcq.size() > 0) void'(srcq.pop_front());
      end
      if (ev_hs) begin
        m_send = 1'b0;
        m_wait = 1'b1;
        m_age  = 0;
        idx    = int'(m_wc);
        if (idx < NW && pl_delay[idx] > 0) begin
          dec_pend = 1'b1;
          dec_at   = cyc + pl_delay[idx];
          dec_word = m_cur ^ {3'b000, pl_corrupt[idx]};
        end
      end else if (m_wait) begin
        m_age++;
        if (ev_dv) begin
          m_wait = 1'b0;
          m_wc   = sat(m_wc);
          if (ev_dd != m_cur) m_ec = sat(m_ec);
          if (m_wc == 16'(NW)) m_done = 1'b1;
          else                 m_fetch = 1'b1;
        end else if (m_age == TO) begin
          m_wait = 1'b0;
          m_wc   = sat(m_wc);
          m_ec   = sat(m_ec);
          m_tc   = sat(m_tc);
          m_rst_left = RC;
        end
      end
    end
    chk("src_ready", 32'(src_ready), 32'(m_fetch));
    chk("enc_valid", 32'(enc_valid), 32'(m_send));
    chk("dp_reset", 32'(dp_reset), 32'(m_rst_left > 0));
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(m_done));
    chk("word_count", 32'(word_count), 32'(m_wc));
    chk("err_count", 32'(err_count), 32'(m_ec));
    chk("timeout_count", 32'(timeout_count), 32'(m_tc));
    if (m_send || ev_rst) chk("enc_data", 32'(enc_data), 32'(m_cur));
    // next inputs
    if (srcq.size() > 0) begin
      src_valid = rnd_src ? 1'($urandom_range(0, 1)) : 1'b1;
      src_data  = src_valid ? srcq[0] : 4'($urandom_range(0, 15));
    end else begin
      src_valid = rnd_src ? 1'($urandom_range(0, 1)) : 1'b0;
      src_data  = 4'($urandom_range(0, 15));
    end
    if (m_send && hold_left > 0) begin
      enc_ready = 1'b0;
      hold_left--;
    end else begin
      enc_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    if (dec_pend && dec_at == cyc + 1) begin
      dec_valid = 1'b1;
      dec_data  = dec_word;
      dec_pend  = 1'b0;
    end else begin
      dec_valid = stray_dec && !m_wait && ($urandom_range(0, 3) == 0);
      dec_data  = 4'($urandom_range(0, 15));
    end
    start = stray_start && m_active && ($urandom_range(0, 3) == 0);
  endtask

  // Start a run with the words already queued and step until it completes.
  task automatic run(input string tag);
    logic seen;
    seen  = 1'b0;
    start = 1'b1;
    step();
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      if (m_done) seen = 1'b1;
    end
    chk({tag, "_completes"}, 32'(seen), 32'd1);
    step();
  endtask

  task automatic load(input logic [15:0] w);
    srcq.delete();
    for (int i = 0; i < NW; i++) srcq.push_back(w[15-4*i -: 4]);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int exp_e, exp_t;
    logic reached;
    set_plan(40);
    reset_original = 1'b1;
    repeat (3) step();
    reset_original = 1'b0;
    step();

    // Loopback, words 3,A,F,0
    load(16'h3AF0);
    run("t1");
    chk("t1_word_count", 32'(word_count), 32'd4);
    chk("t1_err_count", 32'(err_count), 32'd0);

    // One corrupted word
    load(16'h3AF0);
    pl_corrupt[2] = 1'b1;
    run("t2");
    chk("t2_err_count", 32'(err_count), 32'd1);
    chk("t2_timeout_count", 32'(timeout_count), 32'd0);
    chk("t2_word_count", 32'(word_count), 32'd4);

    // Lost word 1
    set_plan(40);
    pl_delay[1] = 0;
    load(16'h1234);
    run("t3");
    chk("t3_timeout_count", 32'(timeout_count), 32'd1);
    chk("t3_err_count", 32'(err_count), 32'd1);
    chk("t3_word_count", 32'(word_count), 32'd4);

    // Decode arriving on the last timer cycle
    set_plan(TO);
    load(16'h9C5E);
    run("t4");
    chk("t4_err_count", 32'(err_count), 32'd0);
    chk("t4_timeout_count", 32'(timeout_count), 32'd0);

    // Encoder stall with a toggling source
    set_plan(40);
    rnd_src   = 1'b1;
    hold_left = 10;
    load(16'h5678);
    run("t5");
    chk("t5_hold_used", 32'(hold_left), 32'd0);
    chk("t5_err_count", 32'(err_count), 32'd0);

    // Reset during WAIT, then stray dec_valid in IDLE, then stray starts mid-run
    load(16'hBEEF);
    start = 1'b1;
    step();
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      step();
      if (m_wait && m_age == 5) reached = 1'b1;
    end
    chk("t6_reached_wait", 32'(reached), 32'd1);
    reset_original = 1'b1;
    step();
    reset_original = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_dp_reset", 32'(dp_reset), 32'd0);
    chk("t6_word_count", 32'(word_count), 32'd0);
    stray_dec = 1'b1;
    repeat (20) step();
    chk("t6_idle_err", 32'(err_count), 32'd0);
    stray_start = 1'b1;
    load(16'hC0DE);
    run("t6");
    chk("t6_run_words", 32'(word_count), 32'd4);
    chk("t6_run_err", 32'(err_count), 32'd0);

    // Randomised runs; totals also derived directly from the plan
    rnd_ready = 1'b1;
    for (int r = 0; r < 20; r++) begin
      exp_e = 0;
      exp_t = 0;
      for (int i = 0; i < NW; i++) begin
        case ($urandom_range(0, 9))
          0:       pl_delay[i] = 0;
          1:       pl_delay[i] = TO + int'($urandom_range(1, 5));
          2:       pl_delay[i] = TO;
          default: pl_delay[i] = int'($urandom_range(1, TO - 1));
        endcase
        pl_corrupt[i] = ($urandom_range(0, 3) == 0);
        if (pl_delay[i] == 0 || pl_delay[i] > TO) begin
          exp_e++;
          exp_t++;
        end else if (pl_corrupt[i]) begin
          exp_e++;
        end
      end
      load(16'($urandom_range(0, 65535)));
      run("rand");
      chk("rand_err_total", 32'(err_count), 32'(exp_e));
      chk("rand_timeout_total", 32'(timeout_count), 32'(exp_t));
      chk("rand_word_total", 32'(word_count), 32'd4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
